// File: rtl/bus_sched_pkg.sv
// bus_sched_pkg: shared types and constants for the bidirectional bus scheduler
package bus_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TURN = 2'd1, XFER = 2'd2} state_e;
  localparam logic DIR_READ = 1'b0;
  localparam logic DIR_WRITE = 1'b1;
  localparam int ST_BUSY = 7;
  localparam int ST_DIR = 6;
  localparam int ST_STATE_LO = 4;
  localparam int ST_OWNER_LO = 0;
endpackage

// File: rtl/bus_rr_pick.sv
// bus_rr_pick: combinational round-robin winner select starting at ptr
module bus_rr_pick #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      idx = req[j] ? j : idx;
    end
    any = |req;
    oh = '0;
    oh[idx] = any;
  end
endmodule

// File: rtl/bidir_bus_sched.sv
// bidir_bus_sched: round-robin bidirectional bus scheduler with bounded bursts and turnaround
module bidir_bus_sched
  import bus_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 16,
  parameter int MAX_BURST = 8,
  parameter int TA_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_wr,
  input  logic [N_REQ-1:0]        req_last,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic                    beat,
  output logic [DATA_W-1:0]       rdata,
  output logic                    rvalid,
  output logic [DATA_W-1:0]       bus_o,
  output logic                    bus_oe,
  input  logic [DATA_W-1:0]       bus_i,
  output logic [7:0]              status
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  state_e state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  logic [IW:0] owner_inc;
  logic [N_REQ-1:0] own_oh_q, own_oh_d, gnt_q, gnt_d, pick_oh;
  logic pick_any, dir_q, dir_d, last_dir_q, last_dir_d, bus_oe_q, bus_oe_d, rvalid_q, rvalid_d, burst_end;
  logic [2:0] ta_q, ta_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  bus_rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .oh  (pick_oh),
    .idx (pick_idx),
    .any (pick_any)
  );
  assign beat = state_q == XFER && req[owner_q];
  assign bus_o = (state_q == XFER && dir_q == DIR_WRITE) ? req_wdata[owner_q*DATA_W +: DATA_W] : '0;
  assign owner_inc = {1'b0, owner_q} + (IW+1)'(1);
  // a dropped request ends the burst without a beat; otherwise last or the beat cap ends it
  assign burst_end = state_q == XFER && (!req[owner_q] || req_last[owner_q] || bcnt_q == CW'(MAX_BURST - 1));
  assign gnt = gnt_q;
  assign bus_oe = bus_oe_q;
  assign rdata = rdata_q;
  assign rvalid = rvalid_q;
  always_comb begin
    status = '0;
    status[ST_BUSY] = state_q != IDLE;
    status[ST_DIR] = dir_q;
    status[ST_STATE_LO +: 2] = state_q;
    status[ST_OWNER_LO +: 4] = 4'(owner_q);
  end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    own_oh_d = own_oh_q;
    dir_d = dir_q;
    last_dir_d = last_dir_q;
    ptr_d = ptr_q;
    ta_d = ta_q;
    bcnt_d = bcnt_q;
    gnt_d = gnt_q;
    bus_oe_d = bus_oe_q;
    rvalid_d = beat && dir_q == DIR_READ;
    rdata_d = rvalid_d ? bus_i : rdata_q;
    case (state_q)
      IDLE: if (pick_any) begin
        owner_d = pick_idx;
        own_oh_d = pick_oh;
        dir_d = req_wr[pick_idx];
        if (dir_d != last_dir_q && TA_CYC > 0) begin
          state_d = TURN;
          ta_d = 3'(TA_CYC - 1);
        end else begin
          state_d = XFER;
          gnt_d = pick_oh;
          last_dir_d = dir_d;
          bus_oe_d = dir_d == DIR_WRITE;
          bcnt_d = '0;
        end
      end
      TURN: if (ta_q == '0) begin
        state_d = XFER;
        gnt_d = own_oh_q;
        last_dir_d = dir_q;
        bus_oe_d = dir_q == DIR_WRITE;
        bcnt_d = '0;
      end else begin
        ta_d = ta_q - 3'd1;
      end
      XFER: begin
        bcnt_d = beat ? bcnt_q + CW'(1) : bcnt_q;
        if (burst_end) begin
          state_d = IDLE;
          gnt_d = '0;
          bus_oe_d = 1'b0;
          ptr_d = (owner_inc == (IW+1)'(N_REQ)) ? '0 : owner_inc[IW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      own_oh_q <= '0;
      dir_q <= DIR_READ;
      last_dir_q <= DIR_READ;
      ptr_q <= '0;
      ta_q <= '0;
      bcnt_q <= '0;
      gnt_q <= '0;
      bus_oe_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      own_oh_q <= own_oh_d;
      dir_q <= dir_d;
      last_dir_q <= last_dir_d;
      ptr_q <= ptr_d;
      ta_q <= ta_d;
      bcnt_q <= bcnt_d;
      gnt_q <= gnt_d;
      bus_oe_q <= bus_oe_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: doc/bidir_bus_sched.md
Name: bidir_bus_sched

Overview:
- Schedules a shared 16-bit bidirectional bus between N_REQ requesters.
- Round-robin arbitration, bounded bursts, and idle turnaround cycles on every change of drive direction.
- Owns the bus output enable. The tristate pad (inout) sits one level up; this block sees split bus_o/bus_oe/bus_i.
- Exports an 8-bit status vector for debug and observability.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DATA_W, 16, bus width
- MAX_BURST, 8, max beats per grant (>=1)
- TA_CYC, 1, idle cycles inserted on direction change (0..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req  in  N_REQ  per-requester request; held high for the whole burst
- req_wr  in  N_REQ  direction, 1=write (drive bus), 0=read; sampled at arbitration
- req_last  in  N_REQ  marks final beat of burst
- req_wdata  in  N_REQ*DATA_W  write data, slice i belongs to requester i
- gnt  out  N_REQ  one-hot grant, registered
- beat  out  1  transfer occurs this cycle
- rdata  out  DATA_W  read data, registered
- rvalid  out  1  rdata valid, registered
- bus_o  out  DATA_W  bus drive value
- bus_oe  out  1  bus drive enable, registered
- bus_i  in  DATA_W  bus sampled value
- status  out  8  [7]=busy, [6]=dir, [5:4]=state, [3:0]=owner index

Behaviour:
- Single clock clk. rst is synchronous, active-high.
- Reset values:
  - gnt=0, beat=0, bus_oe=0, bus_o=0, rvalid=0, rdata=0, status=0
  - rr pointer=0, last_dir=read, beat counter=0, state=IDLE
- FSM states: IDLE(0), TURN(1), XFER(2).
- IDLE, if any req:
  - Winner = first i with req[i]=1, searching from ptr upward, modulo N_REQ.
  - Latch owner and dir=req_wr[owner].
  - If dir!=last_dir and TA_CYC>0, go to TURN. Otherwise go to XFER.
- TURN: bus_oe=0 for exactly TA_CYC cycles, then XFER. Requests are not re-sampled during TURN.
- XFER entry: gnt[owner]=1 and last_dir<=dir. If dir=write, bus_oe=1 for the whole XFER.
- Beat condition: beat = XFER & req[owner], combinational.
- Write beat: bus_o = req_wdata slice of owner, combinational. bus_o=0 when not XFER-write.
- Read beat: rdata<=bus_i and rvalid<=1 on the next edge, giving 1-cycle read latency.
- Burst end conditions; on any of them go to IDLE next edge with gnt=0, bus_oe=0, and ptr<=(owner+1) mod N_REQ:
  - (a) beat & req_last[owner]
  - (b) req[owner]=0 in XFER (no beat that cycle)
  - (c) beat count reaches MAX_BURST
- Latency:
  - Request at IDLE cycle t gives gnt at t+1 with no direction change, or t+1+TA_CYC with a turnaround.
  - Back-to-back bursts always have >=1 IDLE cycle between them.
- Direction changes:
  - A direction change in either direction requires a turnaround.
  - The first write after reset turns around, because last_dir resets to read.
- A req on non-owners during a burst is ignored. A req dropped before it is granted is simply not arbitrated.
- Reset mid-burst: on the reset edge, bus_oe drops, gnt clears, and the partial burst is abandoned.
- Status fields:
  - busy = state!=IDLE.
  - Owner index holds the last owner while IDLE.
- Beat counter width: $clog2(MAX_BURST+1). It clears at XFER entry.

Decomposition:
- Package bus_sched_pkg holds:
  - state enum (IDLE/TURN/XFER)
  - DIR_READ/DIR_WRITE constants
  - status bit-position constants
- Sub-module bus_rr_pick: combinational round-robin winner select (req, ptr -> one-hot, index, any).
- FSM, counters and datapath stay in bidir_bus_sched.

Test Plan:
- Reset, then req[2]=1, wr=1, wdata=16'hA5A5, last on 3rd beat -> 1 TURN cycle, gnt=4'b0100 for 3 cycles, bus_oe=1 with bus_o=A5A5, then IDLE, ptr=3.
- Write burst by req0 then read by req1 with bus_i=16'h1234 -> TA_CYC idle cycles with bus_oe=0 between bursts; rvalid pulses one cycle after each read beat with rdata=1234.
- req=4'b1111 held, last every beat -> grants rotate 0,1,2,3,0 with one IDLE cycle between grants.
- req0 write never asserts last -> burst ends after exactly 8 beats; gnt0 drops; req0 re-granted only after a full rotation if others request.
- Owner drops req mid-burst after 2 beats -> beat=0 that cycle, IDLE next edge, no extra rvalid.
- rst asserted during a write XFER -> next edge bus_oe=0, gnt=0, status=0; first request afterwards arbitrates from ptr 0.
